// File: rtl/sha256_target_check_pkg.sv
// Shared types and helpers for the SHA-256 share-target checker.
package sha256_target_check_pkg;

  localparam int unsigned SHA256_DIGEST_W = 256;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Pipeline emits the digest little-end first; byte 0 becomes the most significant byte.
  function automatic logic [SHA256_DIGEST_W-1:0] byte_reverse(
    input logic [SHA256_DIGEST_W-1:0] d
  );
    logic [SHA256_DIGEST_W-1:0] r;
    for (int i = 0; i < SHA256_DIGEST_W / 8; i++) begin
      r[8*i +: 8] = d[SHA256_DIGEST_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_hit_fifo.sv
// Show-ahead synchronous FIFO holding target hits; flush empties it in one cycle.
module sha256_hit_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sha256_target_check.sv
// Tags pipeline digests with nonces, compares against the share target, queues hits for the host.
module sha256_target_check
  import sha256_target_check_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NONCE_W    = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [NONCE_W-1:0]         nonce_base,
  input  logic [NONCE_W-1:0]         nonce_last,
  input  logic [SHA256_DIGEST_W-1:0] target,
  input  logic [SHA256_DIGEST_W-1:0] digest_in,
  input  logic                       digest_valid,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [NONCE_W-1:0]         result_nonce,
  output logic [SHA256_DIGEST_W-1:0] result_digest,
  output logic                       busy,
  output logic                       exhausted,
  output logic                       overflow
);

  localparam int unsigned HalfW  = SHA256_DIGEST_W / 2;
  localparam int unsigned EntryW = NONCE_W + SHA256_DIGEST_W;

  state_e                     state_q, state_d;
  logic [NONCE_W-1:0]         cnt_q, cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_last_q, s1_last_d;
  logic [NONCE_W-1:0]         s1_tag_q, s1_tag_d;
  logic [SHA256_DIGEST_W-1:0] s1_digest_q, s1_digest_d;
  logic                       s1_hi_lt_q, s1_hi_lt_d;
  logic                       s1_hi_eq_q, s1_hi_eq_d;
  logic                       s1_lo_le_q, s1_lo_le_d;
  logic                       exhausted_q, exhausted_d;
  logic                       overflow_q, overflow_d;

  logic [SHA256_DIGEST_W-1:0] v;
  logic                       sample, hit, push, drop;
  logic                       fifo_full, fifo_empty;
  logic [EntryW-1:0]          fifo_rdata;

  assign v      = byte_reverse(digest_in);
  // start outranks everything: the sampling slot and any pending push are discarded.
  assign sample = (state_q == StRun) && digest_valid && !start;
  assign hit    = s1_hi_lt_q | (s1_hi_eq_q & s1_lo_le_q);
  assign push   = s1_valid_q && hit && !start;
  assign drop   = push && fifo_full && !result_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exhausted_d = exhausted_q;
    overflow_d  = overflow_q;
    s1_valid_d  = sample;
    s1_last_d   = sample ? (cnt_q == nonce_last) : s1_last_q;
    s1_tag_d    = sample ? cnt_q : s1_tag_q;
    s1_digest_d = sample ? digest_in : s1_digest_q;
    s1_hi_lt_d  = sample ? (v[SHA256_DIGEST_W-1:HalfW] <  target[SHA256_DIGEST_W-1:HalfW])
                         : s1_hi_lt_q;
    s1_hi_eq_d  = sample ? (v[SHA256_DIGEST_W-1:HalfW] == target[SHA256_DIGEST_W-1:HalfW])
                         : s1_hi_eq_q;
    s1_lo_le_d  = sample ? (v[HalfW-1:0] <= target[HalfW-1:0]) : s1_lo_le_q;
    if (start) begin
      state_d     = StRun;
      cnt_d       = nonce_base;
      exhausted_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (sample) begin
        cnt_d = cnt_q + NONCE_W'(1);
        if (cnt_q == nonce_last) state_d = StDone;
      end
      if (s1_valid_q && s1_last_q) exhausted_d = 1'b1;
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_tag_q    <= '0;
      s1_digest_q <= '0;
      s1_hi_lt_q  <= 1'b0;
      s1_hi_eq_q  <= 1'b0;
      s1_lo_le_q  <= 1'b0;
      exhausted_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_tag_q    <= s1_tag_d;
      s1_digest_q <= s1_digest_d;
      s1_hi_lt_q  <= s1_hi_lt_d;
      s1_hi_eq_q  <= s1_hi_eq_d;
      s1_lo_le_q  <= s1_lo_le_d;
      exhausted_q <= exhausted_d;
      overflow_q  <= overflow_d;
    end
  end

  sha256_hit_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(EntryW)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST),
    .flush_i(start),
    .push_i (push),
    .data_i ({s1_tag_q, s1_digest_q}),
    .pop_i  (result_ready),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign result_valid  = !fifo_empty;
  assign result_nonce  = fifo_rdata[EntryW-1 -: NONCE_W];
  assign result_digest = fifo_rdata[SHA256_DIGEST_W-1:0];
  assign busy          = (state_q == StRun) || s1_valid_q;
  assign exhausted     = exhausted_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_sha256_target_check.sv
// Directed bench for sha256_target_check with hand-computed expectations.
module tb_sha256_target_check;

  localparam logic [255:0] D =
    256'h5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000;
  localparam logic [255:0] V =
    256'h00000000000001272C7EB572D183C9B8DA350B1835B78D3F56CC07C082D78A5C;
  localparam logic [255:0] MISS_D = {256{1'b1}};
  localparam logic [255:0] T_HIT  = {32'h0, 32'hFFFF0000, 192'h0};
  localparam logic [255:0] T_MISS = {64'h0000000000000127, 192'h0};

  logic         CLK, RST, start, digest_valid, result_ready;
  logic [31:0]  nonce_base, nonce_last;
  logic [255:0] target, digest_in;
  logic         result_valid, busy, exhausted, overflow;
  logic [31:0]  result_nonce;
  logic [255:0] result_digest;

  int checks   = 0;
  int failures = 0;

  sha256_target_check #(
    .FIFO_DEPTH(4),
    .NONCE_W   (32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .nonce_base   (nonce_base),
    .nonce_last   (nonce_last),
    .target       (target),
    .digest_in    (digest_in),
    .digest_valid (digest_valid),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_nonce (result_nonce),
    .result_digest(result_digest),
    .busy         (busy),
    .exhausted    (exhausted),
    .overflow     (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] last);
    nonce_base = base;
    nonce_last = last;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic pop();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; digest_valid = 1'b0; result_ready = 1'b0;
    nonce_base = '0; nonce_last = '0; target = '0; digest_in = '0;
    #2 RST = 1'b0;
    #1;
    chk("rst_valid", 256'(result_valid), 256'(0));
    chk("rst_nonce", 256'(result_nonce), 256'(0));
    chk("rst_digest", result_digest, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_flags", 256'({exhausted, overflow}), 256'(0));
    #6 RST = 1'b1;
    step();

    // 1: single hit, base == last
    target = T_HIT;
    do_start(32'h10, 32'h10);
    chk("t1_busy", 256'(busy), 256'(1));
    digest_in = D; digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    chk("t1_lat1", 256'(result_valid), 256'(0));
    step();
    chk("t1_valid", 256'(result_valid), 256'(1));
    chk("t1_nonce", 256'(result_nonce), 256'(32'h10));
    chk("t1_digest", result_digest, D);
    chk("t1_exh", 256'(exhausted), 256'(1));
    pop();
    chk("t1_empty", 256'(result_valid), 256'(0));
    chk("t1_idle", 256'(busy), 256'(0));

    // 2: miss
    target = T_MISS;
    do_start(32'h10, 32'h10);
    chk("t2_exh_clr", 256'(exhausted), 256'(0));
    digest_in = D; digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    step();
    chk("t2_valid", 256'(result_valid), 256'(0));
    chk("t2_exh", 256'(exhausted), 256'(1));

    // 3: V == target is a hit
    target = V;
    do_start(32'h10, 32'h10);
    digest_in = D; digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    step();
    chk("t3_valid", 256'(result_valid), 256'(1));
    chk("t3_nonce", 256'(result_nonce), 256'(32'h10));
    pop();

    // 4: wrap-around stream, hits at idx 1 and 5
    target = T_HIT;
    do_start(32'hFFFFFFFC, 32'h00000003);
    for (int i = 0; i < 8; i++) begin
      digest_in = (i == 1 || i == 5) ? D : MISS_D;
      digest_valid = 1'b1;
      step();
    end
    digest_in = D;
    step();
    digest_valid = 1'b0;
    step();
    chk("t4_exh", 256'(exhausted), 256'(1));
    chk("t4_ovf", 256'(overflow), 256'(0));
    chk("t4_nonce0", 256'(result_nonce), 256'(32'hFFFFFFFD));
    pop();
    chk("t4_nonce1", 256'(result_nonce), 256'(32'h00000001));
    pop();
    chk("t4_empty", 256'(result_valid), 256'(0));

    // 5a: 6 hits into a 4-deep FIFO with no pops
    do_start(32'h100, 32'h105);
    digest_in = D;
    for (int i = 0; i < 6; i++) begin
      digest_valid = 1'b1;
      step();
    end
    digest_valid = 1'b0;
    step();
    chk("t5_ovf", 256'(overflow), 256'(1));
    chk("t5_exh", 256'(exhausted), 256'(1));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_nonce%0d", k), 256'(result_nonce), 256'(32'h100 + k));
      pop();
    end
    chk("t5_empty", 256'(result_valid), 256'(0));

    // 5b: full + push + pop on the same edge
    do_start(32'h100, 32'h104);
    chk("t5b_ovf_clr", 256'(overflow), 256'(0));
    for (int i = 0; i < 5; i++) begin
      digest_valid = 1'b1;
      step();
    end
    digest_valid = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("t5b_ovf", 256'(overflow), 256'(0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5b_nonce%0d", k), 256'(result_nonce), 256'(32'h101 + k));
      pop();
    end
    chk("t5b_empty", 256'(result_valid), 256'(0));

    // 6a: start mid-stream kills the in-flight hit
    do_start(32'h200, 32'h2FF);
    digest_in = D; digest_valid = 1'b1;
    step();
    nonce_base = 32'h300; nonce_last = 32'h3FF; start = 1'b1;
    step();
    start = 1'b0; digest_valid = 1'b0;
    step();
    step();
    chk("t6_killed", 256'(result_valid), 256'(0));
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    step();
    chk("t6_restart", 256'(result_nonce), 256'(32'h300));
    pop();

    // 6b: asynchronous reset mid-stream
    digest_valid = 1'b1;
    step();
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_valid", 256'(result_valid), 256'(0));
    chk("t6_rst_busy", 256'(busy), 256'(0));
    chk("t6_rst_flags", 256'({exhausted, overflow}), 256'(0));
    chk("t6_rst_nonce", 256'(result_nonce), 256'(0));
    RST = 1'b1;
    step();
    step();
    chk("t6_idle_ignore", 256'(result_valid), 256'(0));
    digest_valid = 1'b0;
    do_start(32'h400, 32'h400);
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    step();
    chk("t6_new_base", 256'(result_nonce), 256'(32'h400));
    chk("t6_exh", 256'(exhausted), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
